// File: rtl/sync_frame_pkg.sv
// Constants shared by the 1001-framed serial link transmitter and receiver.
package sync_frame_pkg;

    localparam int         SYNC_LEN  = 4;
    localparam logic [3:0] SYNC_WORD = 4'b1001;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SYNC   = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out register: loads a payload, shifts left, exposes the MSB.
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             msb
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= data;
        end else if (shift) begin
            sr <= sr << 1;
        end
    end

    assign msb = sr[WIDTH-1];

endmodule

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync word 1001, payload MSB-first, even parity, GAP idle zeros.
module sync_frame_tx
    import sync_frame_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             busy,
    output logic             frame_done
);

    localparam int CNT_MAX = max3(SYNC_LEN, WIDTH, GAP);
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             parity;
    logic             accept;
    logic             load;
    logic             shift;
    logic             msb;
    logic [1:0]       sync_idx;

    assign din_ready = (state == ST_IDLE) && !reset;
    assign busy      = (state != ST_IDLE);
    assign accept    = din_valid && din_ready;
    assign load      = accept;
    // The first payload bit leaves on the last sync edge, so shifting starts there.
    assign shift     = ((state == ST_SYNC) && (cnt == SYNC_LAST)) || (state == ST_DATA);
    assign sync_idx  = 2'(SYNC_LEN - 2) - cnt[1:0];

    piso_shift_reg #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .data  (din),
        .msb   (msb)
    );

    // dout always carries the bit belonging to the current state and count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            dout       <= 1'b0;
            frame_done <= 1'b0;
            parity     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    dout <= 1'b0;
                    if (accept) begin
                        state  <= ST_SYNC;
                        cnt    <= '0;
                        dout   <= SYNC_WORD[SYNC_LEN-1];
                        parity <= ^din;
                    end
                end
                ST_SYNC: begin
                    if (cnt == SYNC_LAST) begin
                        state <= ST_DATA;
                        cnt   <= '0;
                        dout  <= msb;
                    end else begin
                        cnt  <= cnt + 1'b1;
                        dout <= SYNC_WORD[sync_idx];
                    end
                end
                ST_DATA: begin
                    if (cnt == DATA_LAST) begin
                        state <= ST_PARITY;
                        cnt   <= '0;
                        dout  <= parity;
                    end else begin
                        cnt  <= cnt + 1'b1;
                        dout <= msb;
                    end
                end
                ST_PARITY: begin
                    cnt  <= '0;
                    dout <= 1'b0;
                    if (GAP > 0) begin
                        state <= ST_GAP;
                    end else begin
                        state      <= ST_IDLE;
                        frame_done <= 1'b1;
                    end
                end
                ST_GAP: begin
                    dout <= 1'b0;
                    if (cnt == GAP_LAST) begin
                        state      <= ST_IDLE;
                        cnt        <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    dout  <= 1'b0;
                end
            endcase
        end
    end

endmodule
